// File: rtl/mem_block_responder.sv
// Block read responder: accepts a 4-word block request, waits LATENCY cycles, then streams the block.
// Optional macro WRITE_BACK_EN adds block writes committed in a single COMMIT cycle.
module mem_block_responder #(
  parameter int LATENCY = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [14:0] req_adr,
  input  logic [31:0] wdata0,
  input  logic [31:0] wdata1,
  input  logic [31:0] wdata2,
  input  logic [31:0] wdata3,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_word,
  output logic [1:0]  rsp_idx,
  output logic        rsp_last,
  output logic        wr_done,
  output logic [12:0] served_count
);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    BURST
`ifdef WRITE_BACK_EN
    , COMMIT
`endif
  } stateT;

  stateT       state;
  logic [12:0] baseBlk;
  logic [3:0]  waitCnt;
  logic        valid;
  logic [31:0] word;
  logic [1:0]  idx;
  logic        last;
  logic [12:0] served;

`ifdef WRITE_BACK_EN
  logic        isWrite;
  logic        wrDone;
  logic [31:0] wbuf [4];
  logic [31:0] mem [32768];
  // A word never written reads back as its own address, so the store needs no preload.
  logic [32767:0] written = '0;
  logic        unusedBits;

  assign unusedBits = ^req_adr[1:0];

  function automatic logic [31:0] readWord(input logic [14:0] a);
    return written[a] ? mem[a] : {17'd0, a};
  endfunction

  always_ff @(posedge clk) begin
    if (!rst && state == COMMIT) begin
      for (int i = 0; i < 4; i++) begin
        mem[{baseBlk, 2'(i)}]     <= wbuf[i];
        written[{baseBlk, 2'(i)}] <= 1'b1;
      end
    end
  end

  assign wr_done = wrDone;
`else
  logic unusedBits;

  assign unusedBits = ^{req_write, wdata0, wdata1, wdata2, wdata3, req_adr[1:0]};

  function automatic logic [31:0] readWord(input logic [14:0] a);
    return {17'd0, a};
  endfunction

  assign wr_done = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      valid  <= 1'b0;
      word   <= 32'd0;
      idx    <= 2'd0;
      last   <= 1'b0;
      served <= 13'd0;
`ifdef WRITE_BACK_EN
      wrDone <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            baseBlk <= req_adr[14:2];
            waitCnt <= 4'(LATENCY - 1);
`ifdef WRITE_BACK_EN
            isWrite <= req_write;
            wbuf[0] <= wdata0;
            wbuf[1] <= wdata1;
            wbuf[2] <= wdata2;
            wbuf[3] <= wdata3;
`endif
            state   <= WAIT;
          end
        end
        WAIT: begin
          if (waitCnt == 4'd0) begin
`ifdef WRITE_BACK_EN
            if (isWrite) begin
              state  <= COMMIT;
              wrDone <= 1'b1;
            end else
`endif
            begin
              state <= BURST;
              valid <= 1'b1;
              word  <= readWord({baseBlk, 2'd0});
              idx   <= 2'd0;
              last  <= 1'b0;
            end
          end else begin
            waitCnt <= waitCnt - 4'd1;
          end
        end
        BURST: begin
          // Outputs only move on a handshake, so a stalled beat stays put.
          if (rsp_ready) begin
            if (last) begin
              state <= IDLE;
              valid <= 1'b0;
              word  <= 32'd0;
              idx   <= 2'd0;
              last  <= 1'b0;
              if (served != 13'h1FFF) served <= served + 13'd1;
            end else begin
              idx  <= idx + 2'd1;
              last <= (idx == 2'd2);
              word <= readWord({baseBlk, idx + 2'd1});
            end
          end
        end
`ifdef WRITE_BACK_EN
        COMMIT: begin
          wrDone <= 1'b0;
          state  <= IDLE;
        end
`endif
        default: state <= IDLE;
      endcase
    end
  end

  assign req_ready    = (state == IDLE);
  assign rsp_valid    = valid;
  assign rsp_word     = word;
  assign rsp_idx      = idx;
  assign rsp_last     = last;
  assign served_count = served;

endmodule
